// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then clocks a byte out on device-driven clock edges.
// Define PS2_HOST_TX_TIMEOUT_EN to add a watchdog that aborts a stalled frame after TIMEOUT_CYCLES.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_drv_low,
    output logic       ps2_data_drv_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic             tx_ready_q, tx_ready_d;
    logic             clk_drv_q, clk_drv_d;
    logic             data_drv_q, data_drv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic             fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int               WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Device clock falling edge, seen through the synchroniser
    assign fall = clk_sync_q[2] & ~clk_sync_q[1];

    always_comb begin
        state_d       = state_q;
        clk_sync_d    = {clk_sync_q[1:0], ps2_clk};
        data_sync_d   = {data_sync_q[0], ps2_data};
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        inh_cnt_d     = inh_cnt_q;
        tx_ready_d    = tx_ready_q;
        clk_drv_d     = clk_drv_q;
        data_drv_d    = data_drv_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ack_err_d     = ack_err_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d    = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d  = 4'd0;
                    inh_cnt_d  = '0;
                    ack_err_d  = 1'b0;
                    clk_drv_d  = 1'b1;
                    data_drv_d = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_drv_d  = 1'b0;
                    data_drv_d = 1'b1;
                    state_d    = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            // The first fall after the clock release presents D0; the tenth presents the stop bit
            ST_RTS, ST_SHIFT: begin
                if (fall) begin
                    data_drv_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    state_d    = (bit_cnt_q == 4'd9) ? ST_WAIT_ACK : ST_SHIFT;
                end
            end
            ST_WAIT_ACK: begin
                if (fall) begin
                    ack_err_d = data_sync_q[1];
                    state_d   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync_q[1] && data_sync_q[1]) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                clk_drv_d  = 1'b0;
                data_drv_d = 1'b0;
                busy_d     = 1'b0;
                tx_ready_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Counter restarts on every device edge and on every state change
        wdog_d = '0;
        if (state_q == ST_RTS || state_q == ST_SHIFT ||
            state_q == ST_WAIT_ACK || state_q == ST_WAIT_IDLE) begin
            if (!fall && wdog_q == WDOG_LAST) begin
                clk_drv_d     = 1'b0;
                data_drv_d    = 1'b0;
                busy_d        = 1'b0;
                tx_ready_d    = 1'b1;
                done_d        = 1'b0;
                timeout_err_d = 1'b1;
                state_d       = ST_IDLE;
            end else if (!fall && state_d == state_q) begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            clk_sync_q    <= 3'b111;
            data_sync_q   <= 2'b11;
            shift_q       <= '0;
            bit_cnt_q     <= 4'd0;
            inh_cnt_q     <= '0;
            tx_ready_q    <= 1'b1;
            clk_drv_q     <= 1'b0;
            data_drv_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            inh_cnt_q     <= inh_cnt_d;
            tx_ready_q    <= tx_ready_d;
            clk_drv_q     <= clk_drv_d;
            data_drv_q    <= data_drv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign tx_ready         = tx_ready_q;
    assign ps2_clk_drv_low  = clk_drv_q;
    assign ps2_data_drv_low = data_drv_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ack_err          = ack_err_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard drives the shared pins and reconstructs each frame.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pin, ps2_data_pin;
    logic       tx_ready, clk_drv, data_drv, busy, done, ack_err, timeout_err;

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    logic [9:0] rx_frame;
    logic       rx_start, rx_rts_data, rx_done, rx_ack, rx_busy, rx_ready, rx_idle;
    int         rx_inh;
    int         fall_cyc;

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        logic [9:0] exp_frame;
        logic       exp_ack_err;
    } vec_t;

    // Open-drain wired-AND of host and device drivers
    assign ps2_clk_pin  = ~(clk_drv | dev_clk_low);
    assign ps2_data_pin = ~(data_drv | dev_data_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .ps2_clk          (ps2_clk_pin),
        .ps2_data         (ps2_data_pin),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .ps2_clk_drv_low  (clk_drv),
        .ps2_data_drv_low (data_drv),
        .busy             (busy),
        .done             (done),
        .ack_err          (ack_err),
        .timeout_err      (timeout_err)
    );

    // Frame as the device should see it: data LSB first, odd parity, stop
    function automatic logic [9:0] expFrame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit hold);
        int g;
        g = 0;
        while (!tx_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!tx_ready) checkOutput("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Keyboard model: measures the inhibit, clocks n_clocks bits, samples on rising edges
    task automatic recvFrame(input bit ack_low, input int n_clocks);
        int g;
        rx_inh   = 0;
        rx_done  = 1'b0;
        rx_frame = '0;
        while (clk_drv && rx_inh < 20000) begin
            rx_inh++;
            @(negedge clk);
        end
        rx_rts_data = data_drv;
        repeat (HALF) @(negedge clk);
        rx_start = ps2_data_pin;
        for (int k = 1; k <= n_clocks; k++) begin
            dev_clk_low = 1'b1;
            fall_cyc    = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) rx_frame[k-1] = ps2_data_pin;
            if (k == 10 && ack_low) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            else repeat (HALF) @(negedge clk);
        end
        if (n_clocks == 11) begin
            g = 0;
            while (!done && g < 200) begin
                @(negedge clk);
                g++;
            end
            rx_done  = done;
            rx_ack   = ack_err;
            rx_busy  = busy;
            rx_ready = tx_ready;
            rx_idle  = ps2_clk_pin & ps2_data_pin;
        end
    endtask

    task automatic sendAndCheck(input string tag, input logic [7:0] b, input bit ack_low,
                                input logic [9:0] exp_frame, input logic exp_ack);
        applyStimulus(b, 1'b0);
        checkOutput({tag, "_ack_clr"}, {31'd0, ack_err}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        recvFrame(ack_low, 11);
        checkOutput({tag, "_inhibit"}, rx_inh, INH);
        checkOutput({tag, "_rts_data"}, {31'd0, rx_rts_data}, 32'd1);
        checkOutput({tag, "_start"}, {31'd0, rx_start}, 32'd0);
        checkOutput({tag, "_frame"}, {22'd0, rx_frame}, {22'd0, exp_frame});
        checkOutput({tag, "_done"}, {31'd0, rx_done}, 32'd1);
        checkOutput({tag, "_ack_err"}, {31'd0, rx_ack}, {31'd0, exp_ack});
        checkOutput({tag, "_busy_end"}, {31'd0, rx_busy}, 32'd0);
        checkOutput({tag, "_ready_end"}, {31'd0, rx_ready}, 32'd1);
        checkOutput({tag, "_lines_idle"}, {31'd0, rx_idle}, 32'd1);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_ack_hold"}, {31'd0, ack_err}, {31'd0, exp_ack});
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] rb;
        bit         ra;
        int         g;
        bit         saw_done;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b0};
        vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 10'h300, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 10'h355, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 10'h3FF, 1'b0};
        vecs[5] = '{8'hA7, 1'b1, 10'h2A7, 1'b0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_clk_drv", {31'd0, clk_drv}, 32'd0);
        checkOutput("rst_data_drv", {31'd0, data_drv}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, tx_ready}, 32'd1);

        for (int i = 0; i < 6; i++)
            sendAndCheck($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack_low,
                         vecs[i].exp_frame, vecs[i].exp_ack_err);

        // tx_valid held through a busy frame: only the first byte goes out, the next is taken right after done
        applyStimulus(8'hED, 1'b1);
        tx_data = 8'h11;
        recvFrame(1'b1, 11);
        checkOutput("hold_frame0", {22'd0, rx_frame}, {22'd0, expFrame(8'hED)});
        checkOutput("hold_done0", {31'd0, rx_done}, 32'd1);
        checkOutput("hold_ready0", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        checkOutput("hold_accept", {31'd0, clk_drv}, 32'd1);
        checkOutput("hold_busy", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        recvFrame(1'b1, 11);
        checkOutput("hold_inhibit1", rx_inh, INH);
        checkOutput("hold_frame1", {22'd0, rx_frame}, {22'd0, expFrame(8'h11)});
        checkOutput("hold_done1", {31'd0, rx_done}, 32'd1);
        @(negedge clk);

        // Random bytes and ACK behaviour against the model
        for (int r = 0; r < 5; r++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            sendAndCheck($sformatf("rand%0d", r), rb, ra, expFrame(rb), ~ra);
        end

        // Reset in the middle of SHIFT
        applyStimulus(8'hC3, 1'b0);
        recvFrame(1'b1, 4);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_clk_drv", {31'd0, clk_drv}, 32'd0);
        checkOutput("midrst_data_drv", {31'd0, data_drv}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("midrst_busy_after", {31'd0, busy}, 32'd0);
        sendAndCheck("after_rst", 8'hF4, 1'b1, 10'h2F4, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Device stops clocking after 4 bits
        applyStimulus(8'hA5, 1'b0);
        recvFrame(1'b1, 4);
        g = 0;
        saw_done = 1'b0;
        while (!timeout_err && g < 3000) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
            g++;
        end
        checkOutput("tmo_seen", {31'd0, timeout_err}, 32'd1);
        checkOutput("tmo_delay_ok", {31'd0, ((cyc - fall_cyc) >= TMO) && ((cyc - fall_cyc) <= TMO + 6)}, 32'd1);
        checkOutput("tmo_clk_drv", {31'd0, clk_drv}, 32'd0);
        checkOutput("tmo_data_drv", {31'd0, data_drv}, 32'd0);
        checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
        checkOutput("tmo_no_done", {31'd0, saw_done | done}, 32'd0);
        @(negedge clk);
        checkOutput("tmo_pulse", {31'd0, timeout_err}, 32'd0);
        sendAndCheck("after_tmo", 8'hF4, 1'b1, 10'h2F4, 1'b0);
`else
        g = 0;
        saw_done = 1'b0;
        checkOutput("no_wdog_timeout", {31'd0, timeout_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
